// File: rtl/fifo_pkg.sv
// =============================================================================
// fifo_pkg : shared elaboration-time helpers for the register-based buffers
// Revision : 1.0
// =============================================================================
`default_nettype none

package fifo_pkg;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // Legal geometry: power-of-two depth of at least 2, margin strictly inside it.
    function automatic bit fifo_params_ok(input int unsigned depth,
                                          input int unsigned af_margin);
        return is_pow2(depth) && (depth >= 2) && (af_margin < depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_regmem.sv
// =============================================================================
// fifo_regmem : dual-port register array, synchronous write, async read
// Revision    : 1.0
// =============================================================================
`default_nettype none

module fifo_regmem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/uart_fifo_sync.sv
// =============================================================================
// uart_fifo_sync : single-clock byte FIFO with registered read data and flags
// Revision       : 1.0
// =============================================================================
`default_nettype none

module uart_fifo_sync #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2
) (
    input  logic                       clk_10MGz,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       we,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       re,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    import fifo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);

    if (!fifo_params_ok(DEPTH, AF_MARGIN)) begin : g_bad_params
        $error("uart_fifo_sync: DEPTH must be a power of two >= 2 and AF_MARGIN < DEPTH");
    end

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, almost_full_q;
    logic             overflow_q, underflow_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] mem_rdata;
    logic             wr_ok, rd_ok;

    // Acceptance uses the registered flags only; a pop never frees room for a same-edge push.
    assign wr_ok = we && !full_q;
    assign rd_ok = re && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    fifo_regmem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_10MGz),
        .we_i    (wr_ok && !flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk_10MGz or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            rdata_q       <= '0;
        end else if (flush) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rdata_q  <= mem_rdata;
            end
            if (we && full_q) begin
                overflow_q <= 1'b1;
            end
            if (re && empty_q) begin
                underflow_q <= 1'b1;
            end
            count_q       <= count_d;
            full_q        <= (count_d == FULL_CNT);
            empty_q       <= (count_d == '0);
            almost_full_q <= (count_d >= AF_LEVEL);
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = almost_full_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign rdata       = rdata_q;

endmodule

`default_nettype wire
